binary_to_bcd_seq: RTL and testbench

//  Sequential, parametrised binary-to-BCD converter using iterative shift-and-add-3 (double dabble).

---
 rtl/binary_to_bcd_seq.sv | 135 +++++++++++++
 tb/tb_binary_to_bcd_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/binary_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : binary_to_bcd_seq
// Brief    : Sequential double-dabble binary-to-BCD converter, start/done handshake.
//            Optional macro BCD_SIGNED_EN: two's-complement operand, sign output.
// Revision : 1.0 - initial release
// ============================================================================
module binary_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    in,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf,
  output logic                sign
);

  localparam int c_BCD_W = 4 * DIGITS;
  localparam int c_CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_bin;
  logic [c_BCD_W-1:0] r_dig;
  logic               r_ovf_acc;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_BCD_W-1:0] r_bcd;
  logic               r_ovf;

  logic [WIDTH-1:0]   w_operand;
  logic [c_BCD_W-1:0] w_adj;
  logic [c_BCD_W-1:0] w_dig_nxt;
  logic [WIDTH-1:0]   w_bin_nxt;
  logic               w_ovf_nxt;
  logic               w_ready;
  logic               w_load;
  logic               w_last;

  assign w_ready = (r_state == c_IDLE) || (r_state == c_DONE);
  assign w_load  = w_ready && start;
  assign w_last  = (r_state == c_SHIFT) && (r_cnt == c_CNT_ONE);

  // Add-3 correction on every digit that would reach 10+ after doubling.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign w_adj[4*i +: 4] = (r_dig[4*i +: 4] >= 4'd5) ? (r_dig[4*i +: 4] + 4'd3)
                                                        : r_dig[4*i +: 4];
  end

  assign w_dig_nxt = {w_adj[c_BCD_W-2:0], r_bin[WIDTH-1]};
  assign w_bin_nxt = {r_bin[WIDTH-2:0], 1'b0};
  assign w_ovf_nxt = r_ovf_acc | w_adj[c_BCD_W-1];

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state   <= c_IDLE;
      r_bin     <= '0;
      r_dig     <= '0;
      r_ovf_acc <= 1'b0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE, c_DONE: begin
          if (start) begin
            r_bin     <= w_operand;
            r_dig     <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= c_CNT_INIT;
            r_state   <= c_SHIFT;
          end else begin
            r_state   <= c_IDLE;
          end
        end
        c_SHIFT: begin
          r_bin     <= w_bin_nxt;
          r_dig     <= w_dig_nxt;
          r_ovf_acc <= w_ovf_nxt;
          r_cnt     <= r_cnt - c_CNT_ONE;
          if (r_cnt == c_CNT_ONE) begin
            r_bcd   <= w_dig_nxt;
            r_ovf   <= w_ovf_nxt;
            r_state <= c_DONE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

`ifdef BCD_SIGNED_EN
  localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic r_neg;
  logic r_sign;

  // Most negative value negates to itself, which reads correctly as an unsigned magnitude.
  assign w_operand = in[WIDTH-1] ? (~in + c_ONE) : in;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_neg  <= 1'b0;
      r_sign <= 1'b0;
    end else begin
      if (w_load) r_neg <= in[WIDTH-1];
      if (w_last) r_sign <= r_neg;
    end
  end

  assign sign = r_sign;
`else
  assign w_operand = in;
  assign sign      = 1'b0;
`endif

  assign ready = w_ready;
  assign busy  = (r_state == c_SHIFT);
  assign done  = (r_state == c_DONE);
  assign bcd   = r_bcd;
  assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_binary_to_bcd_seq.sv
`default_nettype none
// Bench for binary_to_bcd_seq: 8-bit and 16-bit instances against an arithmetic model.
module tb_binary_to_bcd_seq;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic [7:0]  in8 = '0;
  logic [15:0] in16 = '0;
  logic        ready8, busy8, done8, ovf8, sign8;
  logic        ready16, busy16, done16, ovf16, sign16;
  logic [15:0] bcd8, bcd16;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(4)) dut8 (
    .clk(clk), .clr_n(clr_n), .start(start8), .in(in8),
    .ready(ready8), .busy(busy8), .done(done8), .bcd(bcd8), .ovf(ovf8), .sign(sign8)
  );

  binary_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) dut16 (
    .clk(clk), .clr_n(clr_n), .start(start16), .in(in16),
    .ready(ready16), .busy(busy16), .done(done16), .bcd(bcd16), .ovf(ovf16), .sign(sign16)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic is_neg(input longint v, input int w);
`ifdef BCD_SIGNED_EN
    return v >= (longint'(1) << (w - 1));
`else
    return 1'b0;
`endif
  endfunction

  function automatic longint magnitude(input longint v, input int w);
    if (is_neg(v, w)) return (longint'(1) << w) - v;
    return v;
  endfunction

  function automatic logic [15:0] dec4(input longint v);
    logic [15:0] o;
    longint r;
    r = v % 10000;
    for (int i = 0; i < 4; i++) begin
      o[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return o;
  endfunction

  int          m_left [2];
  logic        m_done [2];
  logic [15:0] m_bcd  [2];
  logic        m_ovf  [2];
  logic        m_sign [2];
  logic [15:0] p_bcd  [2];
  logic        p_ovf  [2];
  logic        p_sign [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_done[k] = 0; m_bcd[k] = 0; m_ovf[k] = 0; m_sign[k] = 0;
      p_bcd[k] = 0; p_ovf[k] = 0; p_sign[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      longint v, mag;
      logic   s;
      int     w;
      v = (k == 0) ? longint'(in8) : longint'(in16);
      s = (k == 0) ? start8 : start16;
      w = (k == 0) ? 8 : 16;
      if (!clr_n) begin
        m_left[k] = 0; m_done[k] = 0; m_bcd[k] = 0; m_ovf[k] = 0; m_sign[k] = 0;
      end else if (m_left[k] > 0) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_done[k] = 1; m_bcd[k] = p_bcd[k]; m_ovf[k] = p_ovf[k]; m_sign[k] = p_sign[k];
        end
      end else begin
        m_done[k] = 0;
        if (s) begin
          mag       = magnitude(v, w);
          m_left[k] = w;
          p_bcd[k]  = dec4(mag);
          p_ovf[k]  = (mag > 9999);
          p_sign[k] = is_neg(v, w);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("outs8",  {ready8, busy8, done8, ovf8, sign8, bcd8},
          {m_left[0] == 0, m_left[0] != 0, m_done[0], m_ovf[0], m_sign[0], m_bcd[0]});
      chk("outs16", {ready16, busy16, done16, ovf16, sign16, bcd16},
          {m_left[1] == 0, m_left[1] != 0, m_done[1], m_ovf[1], m_sign[1], m_bcd[1]});
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic go(input int k, input logic [15:0] v);
    @(negedge clk);
    if (k == 0) begin start8 = 1'b1; in8 = v[7:0]; end
    else        begin start16 = 1'b1; in16 = v; end
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0;
  endtask

  task automatic wait_done(input int k, output int cyc);
    cyc = 0;
    while (((k == 0) ? done8 : done16) !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 60) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done after %0d cycles want done", cyc);
    end
  endtask

  initial begin
    int c, hits;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ready8", ready8, 1);
    chk("rst_bcd8",   bcd8,   0);
    chk("rst_busy16", busy16, 0);
    clr_n = 1'b1;

`ifdef BCD_SIGNED_EN
    go(0, 16'h0080); wait_done(0, c);
    chk("t6_lat", c, 8); chk("t6_80_bcd", bcd8, 16'h0128); chk("t6_80_sign", sign8, 1);
    go(0, 16'h00F6); wait_done(0, c);
    chk("t6_f6_bcd", bcd8, 16'h0010); chk("t6_f6_sign", sign8, 1);
    go(0, 16'h007F); wait_done(0, c);
    chk("t6_7f_bcd", bcd8, 16'h0127); chk("t6_7f_sign", sign8, 0);
`else
    go(0, 16'd255); wait_done(0, c);
    chk("t1_lat", c, 8); chk("t1_bcd", bcd8, 16'h0255); chk("t1_ovf", ovf8, 0);
`endif

    go(0, 16'd0); wait_done(0, c);
    chk("t2_bcd", bcd8, 16'h0000); chk("t2_ready", ready8, 1); chk("t2_busy", busy8, 0);
    @(negedge clk);
    chk("t2_pulse_width", done8, 0);

    go(0, 16'd200);
    repeat (2) @(negedge clk);
    start8 = 1'b1; in8 = 8'd99;
    @(negedge clk);
    start8 = 1'b0; in8 = 8'hAA;
    wait_done(0, c);
`ifdef BCD_SIGNED_EN
    chk("t3_bcd", bcd8, 16'h0056);
`else
    chk("t3_bcd", bcd8, 16'h0200);
`endif
    start8 = 1'b1; in8 = 8'd37;
    @(negedge clk);
    start8 = 1'b0;
    wait_done(0, c);
    chk("t3_b2b_gap", c + 1, 9); chk("t3_b2b_bcd", bcd8, 16'h0037);
    @(negedge clk);

    go(0, 16'd123);
    repeat (3) @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    chk("t4_rst_bcd", bcd8, 0); chk("t4_rst_ready", ready8, 1);
    clr_n = 1'b1;
    hits = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) hits++;
    end
    chk("t4_no_done", hits, 0);
    go(0, 16'd42); wait_done(0, c);
    chk("t4_bcd", bcd8, 16'h0042);

    go(1, 16'hFFFF); wait_done(1, c);
    chk("t5_lat", c, 16);
`ifdef BCD_SIGNED_EN
    chk("t5_bcd", bcd16, 16'h0001); chk("t5_sign", sign16, 1);
`else
    chk("t5_bcd", bcd16, 16'h5535); chk("t5_ovf", ovf16, 1);
`endif
    go(1, 16'd9999); wait_done(1, c);
    chk("t5b_bcd", bcd16, 16'h9999); chk("t5b_ovf", ovf16, 0);

    repeat (3000) begin
      @(negedge clk);
      start8  = ($urandom_range(0, 3) == 0);
      in8     = 8'($urandom);
      start16 = ($urandom_range(0, 3) == 0);
      in16    = 16'($urandom);
      clr_n   = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0; clr_n = 1'b1;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
